dsp: RTL and testbench
======================

// Module: dsp
// PURPOSE
// - Pipelined 18x18 multiply-accumulate slice modelled on the Spartan-6 DSP48A1.
// - Datapath: 18-bit pre-adder (D +/- B), unsigned 18x18 multiplier, then a 48-bit post-adder/subtractor with carry.
// - Leaf arithmetic block for filters and accumulators; cascades via BCIN/BCOUT and PCIN/PCOUT.
// PARAMETERS
// - A0REG 1 / A1REG 1: first/second A pipeline stage (1 = registered, 0 = pass-through).
// - B0REG 1 / B1REG 1: B stage before/after the pre-adder.
// - CREG 1, DREG 1, MREG 1, PREG 1: C, D, multiplier-output and P registers.
// - CARRYINREG 1, CARRYOUTREG 1, OPMODEREG 1: carry-in, carry-out and OPMODE registers.
// - CARRYINSEL "OPMODE5": "OPMODE5" = carry-in from OPMODE[5]; "CARRYIN" = from the CARRYIN port.
// - B_INPUT "DIRECT": "DIRECT" = B port; "CASCADE" = BCIN port.
// - RSTTYPE "SYNC": only legal value; any other value is rejected at elaboration.
// PORTS
// - CLK        in   1   clock; all registers update on the rising edge.
// - RST_N      in   1   synchronous, active-low reset for every pipeline register.
// - A, B, D    in   18  multiplier operand, pre-adder operand, pre-adder operand.
// - C          in   48  post-adder operand.
// - BCIN       in   18  cascaded B input.
// - PCIN       in   48  cascaded P input.
// - OPMODE     in   8   operation select.
// - CARRYIN    in   1   external carry-in.
// - CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE  in  1 each  clock enable of the matching register group.
// - BCOUT      out  18  B1-stage value.
// - M          out  36  multiplier stage value.
// - P, PCOUT   out  48  result; PCOUT equals P.
// - CARRYOUT, CARRYOUTF  out  1  post-adder carry/borrow; CARRYOUTF equals CARRYOUT.
// BEHAVIOUR
// - Registers: RST_N=0 at a clock edge clears the register to 0, overriding its CE. Otherwise the register loads when its CE=1 and holds when CE=0.
// - A register whose xREG parameter is 0 is a wire; its CE has no effect.
// - Reset values (all REG=1): P=PCOUT=0, M=0, BCOUT=0, CARRYOUT=CARRYOUTF=0.
// - B source: B_INPUT selects B or BCIN, which feeds the B0 stage. A feeds A0 then A1. D feeds the DREG stage.
// - Pre-adder: OPMODE[4]=0 -> B1 input = B0 out.
//   OPMODE[4]=1 and OPMODE[6]=0 -> D+B0; OPMODE[4]=1 and OPMODE[6]=1 -> D-B0. Result is 18 bits, modulo 2^18.
// - Multiplier: A1*B1, unsigned 36 bits, feeds the M stage. BCOUT = B1 stage output.
// - X mux (OPMODE[1:0]): 00=0, 01=zero-extended M, 10=P, 11={D[11:0],A1,B1}.
// - Z mux (OPMODE[3:2]): 00=0, 01=PCIN, 10=P, 11=C stage output.
// - CIN = CARRYINSEL source, passed through the CYI stage.
// - Post-adder: OPMODE[7]=0 -> Z+X+CIN; OPMODE[7]=1 -> Z-(X+CIN). Computed 49 bits wide.
//   Bits [47:0] go to the P stage; bit 48 (carry, or borrow on subtract) goes to the CARRYOUT stage.
//   Overflow wraps modulo 2^48.
// - OPMODE stage output drives the pre-adder, the X/Z muxes and the post-adder alike.
// - Latency with all REG=1: A/B/D -> M 3 clocks, -> P 4 clocks. C -> P 2 clocks. OPMODE -> P 2 clocks.
// - When operands change, P may show mixed old/new operands for up to 2 clocks; this is legal.
// - Reset mid-operation: every stage clears on the same edge. P is valid 4 clocks after the first post-reset operand load.
// CONFIGURATION
// - DSP_BCIN_CASCADE_EN defined: B_INPUT="CASCADE" selects BCIN.
// - DSP_BCIN_CASCADE_EN undefined: BCIN is ignored and B is always used, whatever B_INPUT says.
// STRUCTURE
// - Package dsp_pkg: width constants (18/36/48); OPMODE bit-index localparams; X/Z mux encodings; CARRYINSEL/B_INPUT string constants.
// - Sub-module dsp_pipe_reg #(WIDTH, USE_REG): optional register with CE and sync active-low reset.
//   Instantiated once per stage (A0, A1, B0, B1, C, D, M, P, CYI, CYO, OPMODE).
// TESTING
// - RST_N=0 for 3 clocks with random inputs -> P, M, BCOUT, PCOUT, CARRYOUT all 0.
// - All CE=1, OPMODE=8'h1D, A=5 B=6 D=8 C=9 -> M=70, P=79.
//   Then A=10 B=7 D=8 C=10 -> P=160. Then A=110 B=78 D=588 C=160 -> M=73260, P=73420.
// - Pre-subtract: OPMODE=8'h5D, A=3 B=5 D=20 C=1 -> M=45, P=46.
// - Post-subtract with carry: OPMODE=8'hBD, A=4 B=3 D=2 C=100 -> M=20, P=79.
// - Accumulate: OPMODE=8'h09, A=2 B=3 -> P increases by 6 each clock once the pipeline is full.
//   With CEP=0, P holds its value.
// - Overflow: OPMODE=8'h0D, C=48'hFFFF_FFFF_FFFF, A=1 B=1 -> P=0, CARRYOUT=CARRYOUTF=1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the dsp multiply-accumulate slice: datapath widths,
// OPMODE bit positions, X/Z mux encodings and string-valued parameter options.
package dsp_pkg;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int D_W = 18;
    localparam int M_W = 36;
    localparam int P_W = 48;

    localparam int OP_X_LSB   = 0;
    localparam int OP_Z_LSB   = 2;
    localparam int OP_PREADD  = 4;
    localparam int OP_CIN     = 5;
    localparam int OP_PRESUB  = 6;
    localparam int OP_POSTSUB = 7;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    localparam string CARRYINSEL_OPMODE5 = "OPMODE5";
    localparam string CARRYINSEL_CARRYIN = "CARRYIN";
    localparam string B_INPUT_DIRECT     = "DIRECT";
    localparam string B_INPUT_CASCADE    = "CASCADE";
    localparam string RSTTYPE_SYNC       = "SYNC";

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline stage: a clock-enabled register with synchronous active-low
// clear when USE_REG is nonzero, otherwise a plain wire.
module dsp_pipe_reg #(
    parameter int WIDTH   = 18,
    parameter int USE_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (USE_REG != 0) begin : g_reg
            // Clear wins over enable; otherwise load on enable and hold without it
            always_ff @(posedge clk) begin
                if (!rst_n)
                    q <= '0;
                else if (ce)
                    q <= d;
            end
        end else begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp.sv
// Pipelined 18x18 multiply-accumulate slice in the style of the DSP48A1:
// pre-adder, unsigned multiplier, 48-bit post-adder with carry.
// Build option: define DSP_BCIN_CASCADE_EN to let B_INPUT="CASCADE" take BCIN;
// without it the B port always feeds the B0 stage.
module dsp
    import dsp_pkg::*;
#(
    parameter int    A0REG       = 1,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 1,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [A_W-1:0]  a,
    input  logic [B_W-1:0]  b,
    input  logic [D_W-1:0]  d,
    input  logic [P_W-1:0]  c,
    input  logic [B_W-1:0]  bcin,
    input  logic [P_W-1:0]  pcin,
    input  logic [7:0]      opmode,
    input  logic            carryin,
    input  logic            cea,
    input  logic            ceb,
    input  logic            cec,
    input  logic            ced,
    input  logic            cem,
    input  logic            cep,
    input  logic            cecarryin,
    input  logic            ceopmode,
    output logic [B_W-1:0]  bcout,
    output logic [M_W-1:0]  m,
    output logic [P_W-1:0]  p,
    output logic [P_W-1:0]  pcout,
    output logic            carryout,
    output logic            carryoutf
);

    generate
        if (RSTTYPE != RSTTYPE_SYNC) begin : g_bad_rsttype
            $error("dsp: RSTTYPE must be \"SYNC\"");
        end
    endgenerate

    logic [B_W-1:0] b_src;
    logic [A_W-1:0] a0_q, a1_q;
    logic [B_W-1:0] b0_q, b1_d, b1_q;
    logic [D_W-1:0] d_q;
    logic [P_W-1:0] c_q;
    logic [7:0]     op_q;
    logic [M_W-1:0] m_d, m_q;
    logic           cin_d, cin_q;
    logic [P_W-1:0] x_mux, z_mux, p_q;
    logic [P_W:0]   sum;
    logic           co_q;

`ifdef DSP_BCIN_CASCADE_EN
    assign b_src = (B_INPUT == B_INPUT_CASCADE) ? bcin : b;
`else
    logic unused_bcin;
    assign unused_bcin = ^bcin;
    assign b_src = b;
`endif

    dsp_pipe_reg #(.WIDTH(A_W), .USE_REG(A0REG)) u_a0 (.clk(clk), .rst_n(rst_n), .ce(cea), .d(a), .q(a0_q));
    dsp_pipe_reg #(.WIDTH(A_W), .USE_REG(A1REG)) u_a1 (.clk(clk), .rst_n(rst_n), .ce(cea), .d(a0_q), .q(a1_q));
    dsp_pipe_reg #(.WIDTH(B_W), .USE_REG(B0REG)) u_b0 (.clk(clk), .rst_n(rst_n), .ce(ceb), .d(b_src), .q(b0_q));
    dsp_pipe_reg #(.WIDTH(B_W), .USE_REG(B1REG)) u_b1 (.clk(clk), .rst_n(rst_n), .ce(ceb), .d(b1_d), .q(b1_q));
    dsp_pipe_reg #(.WIDTH(D_W), .USE_REG(DREG))  u_d  (.clk(clk), .rst_n(rst_n), .ce(ced), .d(d), .q(d_q));
    dsp_pipe_reg #(.WIDTH(P_W), .USE_REG(CREG))  u_c  (.clk(clk), .rst_n(rst_n), .ce(cec), .d(c), .q(c_q));
    dsp_pipe_reg #(.WIDTH(8),   .USE_REG(OPMODEREG)) u_op (.clk(clk), .rst_n(rst_n), .ce(ceopmode), .d(opmode), .q(op_q));
    dsp_pipe_reg #(.WIDTH(M_W), .USE_REG(MREG))  u_m  (.clk(clk), .rst_n(rst_n), .ce(cem), .d(m_d), .q(m_q));
    dsp_pipe_reg #(.WIDTH(1),   .USE_REG(CARRYINREG)) u_cyi (.clk(clk), .rst_n(rst_n), .ce(cecarryin), .d(cin_d), .q(cin_q));
    dsp_pipe_reg #(.WIDTH(P_W), .USE_REG(PREG))  u_p  (.clk(clk), .rst_n(rst_n), .ce(cep), .d(sum[P_W-1:0]), .q(p_q));
    dsp_pipe_reg #(.WIDTH(1),   .USE_REG(CARRYOUTREG)) u_cyo (.clk(clk), .rst_n(rst_n), .ce(cep), .d(sum[P_W]), .q(co_q));

    // Pre-adder: pass B0 through, or form D+B0 / D-B0 wrapping at 18 bits
    always_comb begin
        b1_d = b0_q;
        if (op_q[OP_PREADD])
            b1_d = op_q[OP_PRESUB] ? (d_q - b0_q) : (d_q + b0_q);
    end

    assign m_d   = a1_q * b1_q;
    assign cin_d = (CARRYINSEL == CARRYINSEL_CARRYIN) ? carryin : op_q[OP_CIN];

    // X and Z operand selection for the post-adder
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (op_q[OP_X_LSB +: 2])
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_q};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = {d_q[11:0], a1_q, b1_q};
            default: x_mux = '0;
        endcase
        case (op_q[OP_Z_LSB +: 2])
            Z_PCIN:  z_mux = pcin;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    // Post-adder at 49 bits so the top bit carries the carry or borrow
    always_comb begin
        sum = '0;
        if (op_q[OP_POSTSUB])
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_q});
        else
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_q};
    end

    assign bcout     = b1_q;
    assign m         = m_q;
    assign p         = p_q;
    assign pcout     = p_q;
    assign carryout  = co_q;
    assign carryoutf = co_q;

endmodule

// File: tb/tb_dsp.sv
// Directed testbench for the dsp slice with hand-computed expected values.
module tb_dsp;

    logic        clk;
    logic        rst_n;
    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic [7:0]  opmode;
    logic        carryin;
    logic        cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    int total = 0;
    int bad   = 0;

    dsp dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .d(d), .c(c), .bcin(bcin), .pcin(pcin),
        .opmode(opmode), .carryin(carryin),
        .cea(cea), .ceb(ceb), .cec(cec), .ced(ced), .cem(cem), .cep(cep),
        .cecarryin(cecarryin), .ceopmode(ceopmode),
        .bcout(bcout), .m(m), .p(p), .pcout(pcout),
        .carryout(carryout), .carryoutf(carryoutf)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [17:0] av,
                                 input logic [17:0] bv, input logic [17:0] dv,
                                 input logic [47:0] cv);
        opmode = op;
        a = av;
        b = bv;
        d = dv;
        c = cv;
    endtask

    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        rst_n = 1'b0;
        {cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode} = 8'hFF;
        carryin = 1'b0;
        pcin = '0;
        bcin = '0;
        applyStimulus(8'h00, '0, '0, '0, '0);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
                          {16'($urandom), 32'($urandom)});
            pcin    = {16'($urandom), 32'($urandom)};
            bcin    = 18'($urandom);
            carryin = 1'($urandom);
            waitClocks(1);
        end
        checkOutput("rst_p",        p,                   48'd0);
        checkOutput("rst_m",        {12'd0, m},          48'd0);
        checkOutput("rst_bcout",    {30'd0, bcout},      48'd0);
        checkOutput("rst_pcout",    pcout,               48'd0);
        checkOutput("rst_carryout", {47'd0, carryout},   48'd0);

        rst_n   = 1'b1;
        pcin    = '0;
        carryin = 1'b0;
        applyStimulus(8'h1D, 18'd5, 18'd6, 18'd8, 48'd9);
        waitClocks(4);
        checkOutput("mac1_m", {12'd0, m}, 48'd70);
        checkOutput("mac1_p", p,          48'd79);

        applyStimulus(8'h1D, 18'd10, 18'd7, 18'd8, 48'd10);
        waitClocks(4);
        checkOutput("mac2_m", {12'd0, m}, 48'd150);
        checkOutput("mac2_p", p,          48'd160);

        applyStimulus(8'h1D, 18'd110, 18'd78, 18'd588, 48'd160);
        waitClocks(4);
        checkOutput("mac3_bcout", {30'd0, bcout}, 48'd666);
        checkOutput("mac3_m",     {12'd0, m},     48'd73260);
        checkOutput("mac3_p",     p,              48'd73420);

        applyStimulus(8'h5D, 18'd3, 18'd5, 18'd20, 48'd1);
        waitClocks(4);
        checkOutput("presub_bcout", {30'd0, bcout}, 48'd15);
        checkOutput("presub_m",     {12'd0, m},     48'd45);
        checkOutput("presub_p",     p,              48'd46);

        applyStimulus(8'hBD, 18'd4, 18'd3, 18'd2, 48'd100);
        waitClocks(4);
        checkOutput("postsub_m",  {12'd0, m},        48'd20);
        checkOutput("postsub_p",  p,                 48'd79);
        checkOutput("postsub_co", {47'd0, carryout}, 48'd0);

        applyStimulus(8'h8D, 18'd2, 18'd5, 18'd0, 48'd5);
        waitClocks(4);
        checkOutput("borrow_m",  {12'd0, m},        48'd10);
        checkOutput("borrow_p",  p,                 48'hFFFF_FFFF_FFFB);
        checkOutput("borrow_co", {47'd0, carryout}, 48'd1);

        pcin = 48'd1000;
        applyStimulus(8'h05, 18'd1, 18'd1, 18'd0, 48'd0);
        waitClocks(4);
        checkOutput("pcin_p", p, 48'd1001);
        pcin = '0;

        applyStimulus(8'h03, 18'd2, 18'd3, 18'd1, 48'd0);
        waitClocks(4);
        checkOutput("xcat_p", p, {12'd1, 18'd2, 18'd3});

        applyStimulus(8'h00, 18'd2, 18'd3, 18'd0, 48'd0);
        waitClocks(4);
        checkOutput("accclr_p", p, 48'd0);
        applyStimulus(8'h09, 18'd2, 18'd3, 18'd0, 48'd0);
        waitClocks(2);
        checkOutput("acc1_p", p, 48'd6);
        waitClocks(1);
        checkOutput("acc2_p", p, 48'd12);
        waitClocks(1);
        checkOutput("acc3_p", p, 48'd18);
        cep = 1'b0;
        waitClocks(3);
        checkOutput("acchold_p", p, 48'd18);
        cep = 1'b1;
        waitClocks(1);
        checkOutput("accresume_p", p, 48'd24);

        applyStimulus(8'h0D, 18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF);
        waitClocks(4);
        checkOutput("ovf_m",   {12'd0, m},         48'd1);
        checkOutput("ovf_p",   p,                  48'd0);
        checkOutput("ovf_co",  {47'd0, carryout},  48'd1);
        checkOutput("ovf_cof", {47'd0, carryoutf}, 48'd1);

        rst_n = 1'b0;
        waitClocks(1);
        checkOutput("midrst_p",     p,                 48'd0);
        checkOutput("midrst_m",     {12'd0, m},        48'd0);
        checkOutput("midrst_bcout", {30'd0, bcout},    48'd0);
        checkOutput("midrst_co",    {47'd0, carryout}, 48'd0);

        applyStimulus(8'h0D, 18'd1, 18'd1, 18'd0, 48'd10);
        rst_n = 1'b1;
        waitClocks(4);
        checkOutput("postrst_p",  p,                 48'd11);
        checkOutput("postrst_co", {47'd0, carryout}, 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
